instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 117 +++++++++++
 tb/tb_instruction_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// RUN/DONE/FAULT controller that stops fetching at the end of instruction memory.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 114
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic        Fault
);

  localparam logic [29:0] LAST_IDX  = 30'(MEM_WORDS - 1);
  localparam logic [29:0] WORDS_IDX = 30'(MEM_WORDS);
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    RUN,
    DONE,
    FAULT
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst_q, inst_next;
  logic [31:0] pcp4_q, pcp4_next;
  logic        valid_q, valid_next;

  logic        redirect;
  logic [31:0] target;
  logic        target_ok;
  logic [31:0] pc_plus4;

  // Branch wins over jump when both resolve in the same cycle.
  assign redirect  = BranchTaken | JumpTaken;
  assign target    = BranchTaken ? BranchTarget : JumpTarget;
  assign target_ok = (target[1:0] == 2'b00) && (target[31:2] < WORDS_IDX);
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    // NOTE: every output of this block is given a hold value first, so no path leaves it unassigned and no latch is inferred.
    state_next = state;
    pc_next    = pc;
    inst_next  = inst_q;
    pcp4_next  = pcp4_q;
    valid_next = valid_q;

    case (state)
      RUN, DONE: begin
        if (redirect) begin
          valid_next = 1'b0;
          inst_next  = '0;
          if (target_ok) begin
            pc_next    = target;
            pcp4_next  = '0;
            state_next = RUN;
          end else begin
            state_next = FAULT;
          end
        end else if (!Stall) begin
          if (state == RUN) begin
            inst_next  = Instruction;
            pcp4_next  = pc_plus4;
            valid_next = 1'b1;
            // The last word is fetched once; PC parks on it afterwards.
            if (pc[31:2] >= LAST_IDX) state_next = DONE;
            else                      pc_next    = pc_plus4;
          end else begin
            valid_next = 1'b0;
          end
        end
      end
      FAULT: begin
        valid_next = 1'b0;
      end
      default: begin
        state_next = FAULT;
        valid_next = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= RUN;
      pc      <= RESET_PC_ALIGNED;
      inst_q  <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      inst_q  <= inst_next;
      pcp4_q  <= pcp4_next;
      valid_q <= valid_next;
    end
  end

  assign Address           = pc;
  assign IF_ID_Instruction = inst_q;
  assign IF_ID_PCPlus4     = pcp4_q;
  assign IF_ID_Valid       = valid_q;
  assign Halted            = (state == DONE);
  assign Fault             = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/redirect/reset traffic checked against a behavioural model.
module tb_instruction_fetch;

  localparam int          MEM_WORDS = 114;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Halted;
  logic        Fault;

  logic [31:0] mem [MEM_WORDS];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pcp4;
  logic        m_valid;
  logic        m_halted;
  logic        m_faulted;

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Address          (Address),
    .Instruction      (Instruction),
    .Stall            (Stall),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .JumpTaken        (JumpTaken),
    .JumpTarget       (JumpTarget),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .Halted           (Halted),
    .Fault            (Fault)
  );

  always #5 Clk = ~Clk;

  // Combinational instruction memory.
  always_comb begin
    int idx;
    idx = int'(Address[31:2]);
    Instruction = (idx < MEM_WORDS) ? mem[idx] : 32'hDEAD_BEEF;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal_target(input logic [31:0] t);
    return (t % 4 == 0) && (t / 4 < MEM_WORDS);
  endfunction

  task automatic model_edge(input logic rst, input logic stall, input logic br,
                            input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RESET_PC; m_inst = 0; m_pcp4 = 0; m_valid = 0;
      m_halted = 0; m_faulted = 0;
    end else if (m_faulted) begin
      m_valid = 0;
    end else if (br || jp) begin
      tgt = br ? bt : jt;
      m_valid = 0;
      m_inst  = 0;
      if (legal_target(tgt)) begin
        m_pc = tgt; m_pcp4 = 0; m_halted = 0;
      end else begin
        m_faulted = 1; m_halted = 0;
      end
    end else if (stall) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 0;
    end else begin
      m_inst  = mem[m_pc / 4];
      m_pcp4  = m_pc + 4;
      m_valid = 1;
      if (m_pc / 4 == MEM_WORDS - 1) m_halted = 1;
      else                           m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},  Address,           m_pc);
    check({tag, ".inst"},  IF_ID_Instruction, m_inst);
    check({tag, ".pcp4"},  IF_ID_PCPlus4,     m_pcp4);
    check({tag, ".valid"}, 32'(IF_ID_Valid),  32'(m_valid));
    check({tag, ".halt"},  32'(Halted),       32'(m_halted));
    check({tag, ".fault"}, 32'(Fault),        32'(m_faulted));
  endtask

  // One clock edge: drive inputs, advance the model, sample just after the edge.
  task automatic step(input string tag, input logic rst, input logic stall,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    Rst = rst; Stall = stall;
    BranchTaken = br; BranchTarget = bt;
    JumpTaken = jp; JumpTarget = jt;
    model_edge(rst, stall, br, bt, jp, jt);
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  task automatic run(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic do_reset(input string tag, input logic stall);
    step(tag, 1'b1, stall, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic branch(input string tag, input logic [31:0] t);
    step(tag, 1'b0, 1'b0, 1'b1, t, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 6)  return 32'($urandom_range(0, MEM_WORDS - 1) * 4) | 32'($urandom_range(1, 3));
    if (r < 12) return 32'((MEM_WORDS + $urandom_range(0, 2000)) * 4);
    if (r < 14) return $urandom;
    if (r < 35) return 32'((MEM_WORDS - 1 - $urandom_range(0, 3)) * 4);
    return 32'($urandom_range(0, MEM_WORDS - 1) * 4);
  endfunction

  initial begin
    Rst = 1'b1; Stall = 1'b0;
    BranchTaken = 1'b0; BranchTarget = '0;
    JumpTaken = 1'b0; JumpTarget = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i * 4);
    model_edge(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Reset state and sequential fetch.
    do_reset("rst", 1'b0);
    check("rst_address", Address, 32'd0);
    check("rst_valid", 32'(IF_ID_Valid), 32'd0);
    run("seq0");
    check("seq0_inst", IF_ID_Instruction, 32'd0);
    check("seq0_pcp4", IF_ID_PCPlus4, 32'd4);
    run("seq1");
    check("seq1_inst", IF_ID_Instruction, 32'd4);
    check("seq1_pcp4", IF_ID_PCPlus4, 32'd8);
    run("seq2");
    check("seq2_inst", IF_ID_Instruction, 32'd8);
    check("seq2_pcp4", IF_ID_PCPlus4, 32'd12);
    check("seq2_address", Address, 32'd12);

    // Stall at PC=8.
    do_reset("st_rst", 1'b0);
    run("st_run0");
    run("st_run1");
    for (int i = 0; i < 2; i++) begin
      step("stall", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      check("stall_address", Address, 32'd8);
      check("stall_inst", IF_ID_Instruction, 32'd4);
    end
    run("unstall");
    check("unstall_inst", IF_ID_Instruction, 32'd8);

    // Redirect beats stall, branch beats jump.
    step("prio", 1'b0, 1'b1, 1'b1, 32'd40, 1'b1, 32'd80);
    check("prio_address", Address, 32'd40);
    check("prio_valid", 32'(IF_ID_Valid), 32'd0);
    check("prio_inst", IF_ID_Instruction, 32'd0);
    step("jump", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd80);
    check("jump_address", Address, 32'd80);

    // End of memory.
    branch("end_br", 32'd452);
    run("end_fetch");
    check("end_pcp4", IF_ID_PCPlus4, 32'd456);
    check("end_halted", 32'(Halted), 32'd1);
    check("end_address", Address, 32'd452);
    run("end_idle");
    check("end_idle_valid", 32'(IF_ID_Valid), 32'd0);
    step("end_stall", 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    branch("end_restart", 32'd0);
    check("restart_halted", 32'(Halted), 32'd0);
    check("restart_address", Address, 32'd0);
    run("restart_run");

    // Faults: misaligned then out of range.
    branch("flt_mis", 32'd6);
    check("flt_mis_fault", 32'(Fault), 32'd1);
    branch("flt_ignored", 32'd16);
    check("flt_ignored_fault", 32'(Fault), 32'd1);
    run("flt_hold");
    do_reset("flt_rst", 1'b0);
    check("flt_rst_fault", 32'(Fault), 32'd0);
    check("flt_rst_address", Address, RESET_PC);
    branch("flt_oor", 32'd456);
    check("flt_oor_fault", 32'(Fault), 32'd1);
    check("flt_oor_valid", 32'(IF_ID_Valid), 32'd0);
    step("flt_jump", 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd8);
    do_reset("flt_rst2", 1'b0);

    // Reset mid-run while stalled.
    for (int i = 0; i < 5; i++) run("mid_run");
    check("mid_address", Address, 32'd20);
    do_reset("mid_rst", 1'b1);
    check("mid_rst_address", Address, 32'd0);
    check("mid_rst_inst", IF_ID_Instruction, 32'd0);
    check("mid_rst_pcp4", IF_ID_PCPlus4, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    do_reset("rnd_rst", 1'b0);
    for (int n = 0; n < 1500; n++) begin
      logic        r_rst, r_stall, r_br, r_jp;
      logic [31:0] r_bt, r_jt;
      r_rst   = ($urandom_range(0, 99) < (m_faulted ? 15 : 2));
      r_stall = ($urandom_range(0, 99) < 25);
      r_br    = ($urandom_range(0, 99) < 7);
      r_jp    = ($urandom_range(0, 99) < 7);
      r_bt    = rand_target();
      r_jt    = rand_target();
      step("rnd", r_rst, r_stall, r_br, r_bt, r_jp, r_jt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
